uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit-side scheduler for the UART core. It arbitrates two frame sources into a small FIFO: register-block writes on port 0 and an auxiliary source on port 1, such as RX echo or a test pattern. It then sequences the TX engine one frame at a time through the `start_tx`/`tx_done` handshake, gated by `cts_n` flow control. It sits between the register block and the core's `tx_data_i`/`start_tx_i`/`tx_done_o` pins.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4. Number of FIFO entries; must be a power of 2 and at least 2.
- `TIMEOUT`, default 65535. Maximum number of cycles spent in BUSY while waiting for `tx_done_i`.

Ports (clock and reset first):
- `clk`  in  1  Single clock for the whole block.
- `rst`  in  1  Reset: synchronous, active-high. It clears every register and empties the FIFO.
- `s0_valid_i`  in  1  Port 0 (register block) has a frame.
- `s0_data_i`  in  32  Port 0 frame data.
- `s0_ready_o`  out  1  Port 0 accepted this cycle; a transfer occurs on valid&ready.
- `s1_valid_i`, `s1_data_i`, `s1_ready_o`  Same as port 0, for port 1.
- `enable_i`  in  1  Permits new frames to start. It does not abort a frame in flight.
- `cts_n`  in  1  Peripheral clear-to-send, active-low.
- `tx_done_i`  in  1  One-cycle pulse from the TX engine when a frame is complete.
- `start_tx_o`  out  1  One-cycle pulse that launches a frame.
- `tx_data_o`  out  32  Frame data. It is valid with `start_tx_o` and held until the next start.
- `busy_o`  out  1  High when the FSM is not in IDLE.
- `fifo_count_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `timeout_o`  out  1  One-cycle pulse when the BUSY watchdog expires.

## Operation
- **Arbitration (round robin, at most one push per cycle):**
  - No grant is issued when the FIFO is full or `rst` is high.
  - With only one valid requester, that requester is granted.
  - With both valid, the port not granted last is granted; `last_grant` resets to port 1, so port 0 wins the first tie.
  - `sN_ready_o` is the grant. It is combinational from valid and the registered FIFO count. A pop in the same cycle does not free space for a push.
- **FIFO:** circular buffer with wrapping read/write pointers.
  - Push and pop in the same cycle leaves the count unchanged.
  - Count never exceeds `FIFO_DEPTH` and never underflows.
- **FSM states:** IDLE, WAIT_CTS, START, BUSY.
  - IDLE → START when FIFO non-empty, `enable_i`=1 and `cts_n`=0.
  - IDLE → WAIT_CTS when FIFO non-empty, `enable_i`=1 and `cts_n`=1.
  - WAIT_CTS → START when `cts_n`=0 and `enable_i`=1.
  - WAIT_CTS → IDLE when `enable_i`=0.
  - START: `start_tx_o`=1 for exactly one cycle. `tx_data_o` is loaded with the FIFO head at the START entry edge, the head is popped, then → BUSY.
  - BUSY → IDLE on `tx_done_i`=1.
  - BUSY → IDLE when the watchdog reaches `TIMEOUT`, with a `timeout_o` pulse.
- **Watchdog counter:** clears on entry to BUSY, increments each BUSY cycle and saturates. It is compared against `TIMEOUT` with a width of `$clog2(TIMEOUT+1)`.
- **Ignored inputs:**
  - `tx_done_i` is ignored outside BUSY.
  - `cts_n` changes during BUSY are ignored; the core handles mid-frame CTS.
- **`enable_i` deasserted:** a frame in BUSY completes normally; no further frames start.
- **Reset mid-operation:** the FSM returns to IDLE, queued frames are discarded, and no `start_tx_o` is issued in the reset cycle.

## Timing
- **Reset values:**
  - `start_tx_o`=0, `tx_data_o`=0, `busy_o`=0, `fifo_count_o`=0, `timeout_o`=0.
  - Both `sN_ready_o`=0 while `rst`=1.
- **Push to start latency:** a push at edge N updates `fifo_count_o` at N+1. With IDLE, `enable_i`=1 and `cts_n`=0, `start_tx_o` is high in the cycle after N+1, i.e. 2 cycles after the accepting edge.
- **Back-to-back frames:** `tx_done_i` at cycle T → IDLE at T+1 → START at T+2. The minimum gap between starts is therefore 2 cycles plus the frame length.
- **Flow control:** `cts_n` falling while in WAIT_CTS gives START 1 cycle later.
- **Watchdog:** `timeout_o` fires at BUSY cycle `TIMEOUT`. If `tx_done_i` arrives in the same cycle, `tx_done_i` wins and there is no timeout.
- **`busy_o`** is registered from the FSM state.

## Test plan
- **Single push:** with reset then `cts_n`=0, `enable_i`=1, push `s0_data_i`=0x000000A5.
  - `start_tx_o` pulses 2 cycles later with `tx_data_o`=0xA5.
  - A `tx_done_i` pulse returns `busy_o` to 0 one cycle later.
- **Tie arbitration:** hold `s0_valid_i` and `s1_valid_i` continuously with data 0x11 and 0x22, depth 4, `cts_n`=1.
  - Accept order is 0x11, 0x22, 0x11, 0x22, then both ready drop.
  - `fifo_count_o`=4.
- **Full FIFO with concurrent pop:** FIFO full, release `cts_n`.
  - In the pop cycle, `s0_ready_o` stays 0.
  - On the next cycle `s0_ready_o`=1 and the count stays 4 after the push.
- **CTS stall:** `cts_n`=1 with one frame queued.
  - FSM stays in WAIT_CTS for 10 cycles and `start_tx_o` never pulses.
  - `cts_n`→0 gives START 1 cycle later.
- **Watchdog:** `TIMEOUT`=8, start a frame and withhold `tx_done_i`.
  - `timeout_o` pulses on BUSY cycle 8, then the next queued frame starts.
  - Repeat with `tx_done_i` on cycle 8: no timeout.
- **Reset mid-frame:** assert `rst` in BUSY with 3 frames queued.
  - Next cycle: `fifo_count_o`=0, `busy_o`=0, and no `start_tx_o` until a new push.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin merge of two frame sources into a small FIFO, then
// launches TX engine frames one at a time via start_tx/tx_done, gated by enable and cts_n.
module uart_tx_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s0_valid_i,
  input  logic [31:0]                 s0_data_i,
  output logic                        s0_ready_o,
  input  logic                        s1_valid_i,
  input  logic [31:0]                 s1_data_i,
  output logic                        s1_ready_o,
  input  logic                        enable_i,
  input  logic                        cts_n,
  input  logic                        tx_done_i,
  output logic                        start_tx_o,
  output logic [31:0]                 tx_data_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        timeout_o,
  output logic [1:0]                  state_o
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_CTS, START, BUSY} state_t;
  state_t state, state_next;

  logic [31:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           last_grant;
  logic           grant0, grant1, push, pop, full, empty;
  logic [31:0]    push_data;
  logic [WDW-1:0] wd;
  logic           wd_hit;
  logic [31:0]    tx_data;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Handshake: a frame transfers on a port in any cycle where valid and ready are both
  // high; ready is the grant and uses only the registered count, so a same-cycle pop
  // never makes room for a push. last_grant = 1 means port 1 won most recently.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !full) begin
      if (s0_valid_i && (!s1_valid_i || last_grant)) grant0 = 1'b1;
      else if (s1_valid_i)                           grant1 = 1'b1;
    end
  end

  assign push      = grant0 | grant1;
  assign push_data = grant0 ? s0_data_i : s1_data_i;
  assign pop       = (state == START) && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
        last_grant  <= grant1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!empty && enable_i) state_next = cts_n ? WAIT_CTS : START;
      WAIT_CTS: begin
        if (!enable_i)   state_next = IDLE;
        else if (!cts_n) state_next = START;
      end
      START:    state_next = BUSY;
      BUSY:     if (tx_done_i || wd_hit) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Head is captured on the edge entering START so data is valid alongside the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd      <= '0;
      tx_data <= '0;
    end else begin
      if (state_next == START && state != START) tx_data <= mem[rd_ptr];
      if (state != BUSY)  wd <= '0;
      else if (wd != '1)  wd <= wd + 1'b1;
    end
  end

  assign wd_hit = (state == BUSY) && (wd == WD_LAST);

  always_comb begin
    start_tx_o = 1'b0;
    timeout_o  = 1'b0;
    busy_o     = (state != IDLE);
    if (!rst) begin
      start_tx_o = (state == START);
      timeout_o  = wd_hit && !tx_done_i;
    end
  end

  assign tx_data_o    = tx_data;
  assign fifo_count_o = count;
  assign s0_ready_o   = grant0;
  assign s1_ready_o   = grant1;
  assign state_o      = state;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: arbitration/count model plus an expected-data queue checked
// on every start_tx pulse, with directed scenarios for latency, flow control and watchdog.
module tb_uart_tx_sched;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_START = 2'd2, S_BUSY = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic [31:0] s0_data, s1_data, tx_data;
  logic        enable, cts_n, tx_done, start_tx, busy, timeout;
  logic [2:0]  fifo_count;
  logic [1:0]  state;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          model_cnt, n_starts, n_timeouts, tmo_before;
  logic        last_g;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] t2_exp [4] = '{32'h11, 32'h22, 32'h11, 32'h22};

  always #5 clk = ~clk;

  uart_tx_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .s0_valid_i(s0_valid), .s0_data_i(s0_data), .s0_ready_o(s0_ready),
    .s1_valid_i(s1_valid), .s1_data_i(s1_data), .s1_ready_o(s1_ready),
    .enable_i(enable), .cts_n(cts_n), .tx_done_i(tx_done),
    .start_tx_o(start_tx), .tx_data_o(tx_data), .busy_o(busy),
    .fifo_count_o(fifo_count), .timeout_o(timeout), .state_o(state)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: sample away from the edge, score, then advance the model across the edge.
  task automatic tick();
    logic        g0, g1, p;
    logic [31:0] d;
    #1;
    g0 = 1'b0; g1 = 1'b0; p = 1'b0; d = '0;
    if (!rst && model_cnt < DEPTH) begin
      if (s0_valid && (!s1_valid || last_g)) g0 = 1'b1;
      else if (s1_valid)                     g1 = 1'b1;
    end
    d = g0 ? s0_data : s1_data;
    check("s0_ready", 32'(s0_ready), 32'(g0));
    check("s1_ready", 32'(s1_ready), 32'(g1));
    check("fifo_count", 32'(fifo_count), 32'(model_cnt));
    if (s0_valid && s0_ready) acc_q.push_back(s0_data);
    if (s1_valid && s1_ready) acc_q.push_back(s1_data);
    if (timeout) n_timeouts++;
    if (rst) check("start_in_reset", 32'(start_tx), 32'd0);
    else if (start_tx) begin
      n_starts++;
      p = 1'b1;
      check("start_q_empty", 32'(exp_q.size() == 0), 32'd0);
      if (exp_q.size() != 0) check("tx_data", tx_data, exp_q.pop_front());
    end
    @(posedge clk);
    if (rst) begin
      model_cnt = 0;
      exp_q.delete();
      last_g = 1'b1;
    end else begin
      if (g0 | g1) begin
        exp_q.push_back(d);
        last_g = g1;
      end
      model_cnt = model_cnt + int'(g0 | g1) - int'(p);
    end
    #1;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 300; i++) begin
      if (fifo_count == 0 && state == S_IDLE) break;
      tx_done = (state == S_BUSY);
      tick();
    end
    tx_done = 1'b0;
    check(tag, 32'(fifo_count == 0 && state == S_IDLE), 32'd1);
    check("drain_q_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_one(logic [31:0] data);
    s0_valid = 1'b1;
    s0_data  = data;
    tick();
    s0_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; s0_valid = 1'b0; s0_data = '0; s1_valid = 1'b0; s1_data = '0;
    enable = 1'b0; cts_n = 1'b1; tx_done = 1'b0;
    model_cnt = 0; last_g = 1'b1; n_starts = 0; n_timeouts = 0;
    @(posedge clk); #1;
    s0_valid = 1'b1; s1_valid = 1'b1;   // ready must stay low while in reset
    tick(); tick();
    s0_valid = 1'b0; s1_valid = 1'b0; rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_start", 32'(start_tx), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_state", 32'(state), 32'(S_IDLE));

    // Single push: start two cycles after the accepting edge.
    enable = 1'b1; cts_n = 1'b0;
    push_one(32'hA5);
    check("t1_count_after_push", 32'(fifo_count), 32'd1);
    check("t1_no_start_yet", 32'(start_tx), 32'd0);
    tick();
    check("t1_start_pulse", 32'(start_tx), 32'd1);
    check("t1_tx_data", tx_data, 32'hA5);
    tick();
    check("t1_start_one_cycle", 32'(start_tx), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t1_busy_cleared", 32'(busy), 32'd0);

    // Tie arbitration with CTS held off.
    rst = 1'b1; tick(); rst = 1'b0;
    cts_n = 1'b1; enable = 1'b1;
    s0_valid = 1'b1; s0_data = 32'h11; s1_valid = 1'b1; s1_data = 32'h22;
    acc_q.delete();
    repeat (6) tick();
    check("t2_accept_n", 32'(acc_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) check("t2_order", acc_q[i], t2_exp[i]);
    check("t2_count_full", 32'(fifo_count), 32'd4);
    check("t2_s0_ready_low", 32'(s0_ready), 32'd0);
    check("t2_s1_ready_low", 32'(s1_ready), 32'd0);
    check("t2_wait_cts", 32'(state), 32'(S_WAIT));

    // Full FIFO with concurrent pop: no push in the pop cycle.
    s1_valid = 1'b0; s0_data = 32'h33; cts_n = 1'b0;
    tick();
    check("t3_start", 32'(start_tx), 32'd1);
    check("t3_pop_cycle_ready", 32'(s0_ready), 32'd0);
    tick();
    check("t3_ready_after_pop", 32'(s0_ready), 32'd1);
    tick();
    check("t3_count_refilled", 32'(fifo_count), 32'd4);
    s0_valid = 1'b0;
    drain("t3_drain");

    // CTS stall, then release.
    cts_n = 1'b1;
    push_one(32'h44);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t4_stall_state", 32'(state), 32'(S_WAIT));
      check("t4_stall_no_start", 32'(start_tx), 32'd0);
      tick();
    end
    cts_n = 1'b0;
    tick();
    check("t4_start_after_cts", 32'(start_tx), 32'd1);
    tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;

    // enable low holds a queued frame in IDLE.
    enable = 1'b0;
    push_one(32'h45);
    repeat (4) begin
      tick();
      check("t4_disabled_idle", 32'(state), 32'(S_IDLE));
      check("t4_disabled_no_start", 32'(start_tx), 32'd0);
    end
    enable = 1'b1;
    tick();
    check("t4_enable_start", 32'(start_tx), 32'd1);
    drain("t4_drain");

    // Watchdog fires on BUSY cycle TMO, then the next queued frame starts.
    tmo_before = n_timeouts;
    push_one(32'h55);
    s1_valid = 1'b1; s1_data = 32'h66;
    tick();
    s1_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state == S_BUSY) break;
      tick();
    end
    check("t5_reached_busy", 32'(state), 32'(S_BUSY));
    for (int k = 1; k <= TMO; k++) begin
      check("t5_timeout", 32'(timeout), 32'(k == TMO));
      tick();
    end
    check("t5_idle_after_timeout", 32'(state), 32'(S_IDLE));
    tick();
    check("t5_next_start", 32'(start_tx), 32'd1);
    check("t5_next_data", tx_data, 32'h66);
    tick();
    for (int k = 1; k <= TMO; k++) begin
      if (k == TMO) begin
        tx_done = 1'b1;
        #1;
      end
      check("t5b_no_timeout", 32'(timeout), 32'd0);
      tick();
    end
    tx_done = 1'b0;
    check("t5b_idle", 32'(state), 32'(S_IDLE));
    check("t5_timeout_count", 32'(n_timeouts - tmo_before), 32'd1);

    // Reset mid-frame with three frames queued.
    s0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0_data = 32'($urandom_range(32'h00ff_ffff, 0));
      tick();
    end
    s0_valid = 1'b0;
    check("t6_busy_state", 32'(state), 32'(S_BUSY));
    check("t6_queued", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    tick();
    check("t6_count_cleared", 32'(fifo_count), 32'd0);
    check("t6_busy_cleared", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) begin
      tick();
      check("t6_no_start", 32'(start_tx), 32'd0);
    end
    push_one(32'h88);
    drain("t6_drain");
    check("total_starts", 32'(n_starts), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
